// File: rtl/doa_pkg.sv
// Shared types and constants for the direction-of-arrival frame pipeline.
// Beam geometry constants are shared with the weightblock.
package doa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CAP   = 3'd1,
    ST_FFT   = 3'd2,
    ST_DET   = 3'd3,
    ST_WB    = 3'd4,
    ST_PUB   = 3'd5,
    ST_GAP   = 3'd6,
    ST_ERROR = 3'd7
  } seq_state_t;

  typedef enum logic [1:0] {
    STG_CAP = 2'd0,
    STG_FFT = 2'd1,
    STG_DET = 2'd2,
    STG_WB  = 2'd3
  } stage_t;

  localparam int NUM_BEAMS = 13;
  localparam int ANG_STEP  = 15;

  // States in which a pipeline stage is working and the watchdog runs.
  function automatic logic is_stage(input seq_state_t s);
    return (s == ST_CAP) || (s == ST_FFT) || (s == ST_DET) || (s == ST_WB);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: counts cycles while enabled and flags the last allowed
// cycle so the sequencer can abort a stage that never reports done.
module stage_watchdog #(
  parameter int               TMO_W      = 24,
  parameter logic [TMO_W-1:0] TMO_CYCLES = 24'd10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST_CNT = TMO_CYCLES - 1'b1;

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/doa_frame_sequencer.sv
// Frame scheduler for capture -> FFT -> detect -> beam weighting, with a
// watchdog per stage and a latched result published by a one-cycle valid.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for run (continuous) or single (one frame)
// CAP      | capture running, waiting for cap_done
// FFT      | FFT running, waiting for fft_done
// DET      | frequency detect running, waiting for det_done
// WB       | beam weighting running, waiting for wb_done
// PUB      | one cycle: res_valid high, result already latched
// GAP      | inter-frame idle gap, then decide next frame or IDLE
// ERROR    | a stage timed out; held until clr_err
module doa_frame_sequencer
  import doa_pkg::*;
#(
  parameter int               TMO_W      = 24,
  parameter logic [TMO_W-1:0] TMO_CYCLES = 24'd10_000_000,
  parameter int               GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        single,
  input  logic        clr_err,
  output logic        cap_start,
  input  logic        cap_done,
  output logic        fft_start,
  input  logic        fft_done,
  output logic        det_start,
  input  logic        det_done,
  input  logic        det_found,
  output logic        wb_start,
  input  logic        wb_done,
  input  logic [3:0]  wb_bnum,
  input  logic [7:0]  wb_doa,
  output logic [3:0]  res_bnum,
  output logic [7:0]  res_doa,
  output logic        res_valid,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_stage,
  output logic [15:0] frame_cnt,
  output logic [15:0] skip_cnt
);

  localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  seq_state_t       state_q, state_d;
  logic             one_shot_q, one_shot_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  stage_t           err_stage_q, err_stage_d;
  logic [3:0]       res_bnum_q, res_bnum_d;
  logic [7:0]       res_doa_q, res_doa_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      skip_cnt_q, skip_cnt_d;
  logic             cap_start_q, cap_start_d;
  logic             fft_start_q, fft_start_d;
  logic             det_start_q, det_start_d;
  logic             wb_start_q, wb_start_d;

  logic       wdg_clear, wdg_enable, wdg_expired;
  logic       frame_end;
  seq_state_t next_frame_state;

  stage_watchdog #(
    .TMO_W      (TMO_W),
    .TMO_CYCLES (TMO_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wdg_clear),
    .enable  (wdg_enable),
    .expired (wdg_expired)
  );

  assign next_frame_state = (run && !one_shot_q) ? ST_CAP : ST_IDLE;

  always_comb begin
    state_d     = state_q;
    one_shot_d  = one_shot_q;
    gap_d       = gap_q;
    err_stage_d = err_stage_q;
    res_bnum_d  = res_bnum_q;
    res_doa_d   = res_doa_q;
    frame_cnt_d = frame_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    frame_end   = 1'b0;

    // Each stage only listens to its own done; a done beats a same-cycle timeout.
    case (state_q)
      ST_IDLE: begin
        if (run || single) begin
          state_d    = ST_CAP;
          one_shot_d = single && !run;
        end
      end
      ST_CAP: begin
        if (cap_done) begin
          state_d = ST_FFT;
        end else if (wdg_expired) begin
          state_d     = ST_ERROR;
          err_stage_d = STG_CAP;
        end
      end
      ST_FFT: begin
        if (fft_done) begin
          state_d = ST_DET;
        end else if (wdg_expired) begin
          state_d     = ST_ERROR;
          err_stage_d = STG_FFT;
        end
      end
      ST_DET: begin
        if (det_done) begin
          if (det_found) begin
            state_d = ST_WB;
          end else begin
            skip_cnt_d = skip_cnt_q + 16'd1;
            frame_end  = 1'b1;
          end
        end else if (wdg_expired) begin
          state_d     = ST_ERROR;
          err_stage_d = STG_DET;
        end
      end
      ST_WB: begin
        if (wb_done) begin
          state_d     = ST_PUB;
          res_bnum_d  = wb_bnum;
          res_doa_d   = wb_doa;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (wdg_expired) begin
          state_d     = ST_ERROR;
          err_stage_d = STG_WB;
        end
      end
      ST_PUB: begin
        frame_end = 1'b1;
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = next_frame_state;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      ST_ERROR: begin
        if (clr_err) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_end) begin
      if (GAP_CYCLES != 0) begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end else begin
        state_d = next_frame_state;
      end
    end

    if (state_d == ST_IDLE) begin
      one_shot_d = 1'b0;
    end
  end

  assign cap_start_d = (state_d == ST_CAP) && (state_q != ST_CAP);
  assign fft_start_d = (state_d == ST_FFT) && (state_q != ST_FFT);
  assign det_start_d = (state_d == ST_DET) && (state_q != ST_DET);
  assign wb_start_d  = (state_d == ST_WB)  && (state_q != ST_WB);

  assign wdg_clear  = is_stage(state_d) && (state_d != state_q);
  assign wdg_enable = is_stage(state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      one_shot_q  <= 1'b0;
      gap_q       <= '0;
      err_stage_q <= STG_CAP;
      res_bnum_q  <= '0;
      res_doa_q   <= '0;
      frame_cnt_q <= '0;
      skip_cnt_q  <= '0;
      cap_start_q <= 1'b0;
      fft_start_q <= 1'b0;
      det_start_q <= 1'b0;
      wb_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      one_shot_q  <= one_shot_d;
      gap_q       <= gap_d;
      err_stage_q <= err_stage_d;
      res_bnum_q  <= res_bnum_d;
      res_doa_q   <= res_doa_d;
      frame_cnt_q <= frame_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      cap_start_q <= cap_start_d;
      fft_start_q <= fft_start_d;
      det_start_q <= det_start_d;
      wb_start_q  <= wb_start_d;
    end
  end

  assign cap_start = cap_start_q;
  assign fft_start = fft_start_q;
  assign det_start = det_start_q;
  assign wb_start  = wb_start_q;
  assign res_bnum  = res_bnum_q;
  assign res_doa   = res_doa_q;
  assign res_valid = (state_q == ST_PUB);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign err       = (state_q == ST_ERROR);
  assign err_stage = err_stage_q;
  assign frame_cnt = frame_cnt_q;
  assign skip_cnt  = skip_cnt_q;

endmodule

// File: tb/tb_doa_frame_sequencer.sv
// Directed bench for doa_frame_sequencer: stage handshakes answered by tasks,
// expected timings and values worked out by hand.
module tb_doa_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, single, clr_err;
  logic        cap_start, cap_done, fft_start, fft_done;
  logic        det_start, det_done, det_found, wb_start, wb_done;
  logic [3:0]  wb_bnum, res_bnum;
  logic [7:0]  wb_doa, res_doa;
  logic        res_valid, busy, err;
  logic [1:0]  err_stage;
  logic [15:0] frame_cnt, skip_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cap_n = 0, fft_n = 0, det_n = 0, wb_n = 0, valid_n = 0, strobe_bad = 0;
  logic prev_cap = 0, prev_fft = 0, prev_det = 0, prev_wb = 0, prev_valid = 0;

  doa_frame_sequencer #(
    .TMO_W      (24),
    .TMO_CYCLES (24'd100),
    .GAP_CYCLES (16)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .single(single), .clr_err(clr_err),
    .cap_start(cap_start), .cap_done(cap_done),
    .fft_start(fft_start), .fft_done(fft_done),
    .det_start(det_start), .det_done(det_done), .det_found(det_found),
    .wb_start(wb_start), .wb_done(wb_done), .wb_bnum(wb_bnum), .wb_doa(wb_doa),
    .res_bnum(res_bnum), .res_doa(res_doa), .res_valid(res_valid),
    .busy(busy), .err(err), .err_stage(err_stage),
    .frame_cnt(frame_cnt), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe bookkeeping: counts pulses, flags overlaps and pulses wider than one cycle.
  always @(negedge clk) begin
    cap_n   <= cap_n + int'(cap_start);
    fft_n   <= fft_n + int'(fft_start);
    det_n   <= det_n + int'(det_start);
    wb_n    <= wb_n + int'(wb_start);
    valid_n <= valid_n + int'(res_valid);
    if ((int'(cap_start) + int'(fft_start) + int'(det_start) + int'(wb_start)) > 1)
      strobe_bad <= strobe_bad + 1;
    else if ((cap_start && prev_cap) || (fft_start && prev_fft) || (det_start && prev_det) ||
             (wb_start && prev_wb) || (res_valid && prev_valid))
      strobe_bad <= strobe_bad + 1;
    prev_cap   <= cap_start;
    prev_fft   <= fft_start;
    prev_det   <= det_start;
    prev_wb    <= wb_start;
    prev_valid <= res_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic strobe_of(input int st);
    case (st)
      0: return cap_start;
      1: return fft_start;
      2: return det_start;
      default: return wb_start;
    endcase
  endfunction

  task automatic set_done(input int st, input logic v, input logic fnd);
    case (st)
      0: cap_done = v;
      1: fft_done = v;
      2: begin det_done = v; det_found = fnd; end
      default: wb_done = v;
    endcase
  endtask

  // Waits (bounded) for the stage strobe, then optionally returns done dly cycles later.
  task automatic run_stage(input int st, input int dly, input bit give, input bit fnd,
                           output int scyc);
    int n;
    n = 0;
    scyc = -1;
    while (n < 300 && strobe_of(st) !== 1'b1) begin
      tick();
      n++;
    end
    if (strobe_of(st) === 1'b1) begin
      scyc = cyc;
      if (give) begin
        repeat (dly) tick();
        set_done(st, 1'b1, fnd);
        tick();
        set_done(st, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; run = 0; single = 0; clr_err = 0;
    cap_done = 0; fft_done = 0; det_done = 0; det_found = 0; wb_done = 0;
    wb_bnum = 0; wb_doa = 0;
    tick(); tick();
    checks++;
    if ({cap_start, fft_start, det_start, wb_start} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {cap_start, fft_start, det_start, wb_start});
    end
    checks++;
    if ({res_valid, busy, err, err_stage} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {res_valid, busy, err, err_stage});
    end
    checks++;
    if ({res_bnum, res_doa, frame_cnt, skip_cnt} !== 44'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {res_bnum, res_doa, frame_cnt, skip_cnt});
    end
    reset = 0;
    tick();
  endtask

  task automatic test_nominal();
    int c0, cc, fc, dc, wc, p, cc2, x;
    int cap_base;
    cap_base = cap_n;
    wb_bnum = 4'd9; wb_doa = 8'd45;
    c0 = cyc;
    run = 1;
    tick();
    run_stage(0, 5, 1, 1, cc);
    run_stage(1, 5, 1, 1, fc);
    run_stage(2, 5, 1, 1, dc);
    run_stage(3, 5, 1, 1, wc);
    checks++;
    if (cc != c0 + 1 || fc != cc + 6 || dc != fc + 6 || wc != dc + 6) begin
      errors++; $display("FAIL nominal_strobe_times: got cap=%0d fft=%0d det=%0d wb=%0d expected %0d %0d %0d %0d",
                         cc, fc, dc, wc, c0 + 1, c0 + 7, c0 + 13, c0 + 19);
    end
    p = cyc;
    checks++;
    if (res_valid !== 1'b1 || res_bnum !== 4'd9 || res_doa !== 8'd45) begin
      errors++; $display("FAIL nominal_publish: got valid=%b bnum=%0d doa=%0d expected 1 9 45", res_valid, res_bnum, res_doa);
    end
    tick(); tick();
    checks++;
    if (frame_cnt !== 16'd1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL nominal_frame_cnt: got cnt=%0d valid=%b expected 1 0", frame_cnt, res_valid);
    end
    run_stage(0, 5, 1, 1, cc2);
    checks++;
    if (cc2 != p + 17) begin
      errors++; $display("FAIL nominal_gap: got cap_start at %0d expected %0d", cc2, p + 17);
    end
    run = 0;
    wb_bnum = 4'd3; wb_doa = 8'hE2;
    run_stage(1, 2, 1, 1, x);
    run_stage(2, 2, 1, 1, x);
    run_stage(3, 2, 1, 1, x);
    checks++;
    if (res_valid !== 1'b1 || res_bnum !== 4'd3 || res_doa !== 8'hE2) begin
      errors++; $display("FAIL run_drop_publish: got valid=%b bnum=%0d doa=%h expected 1 3 e2", res_valid, res_bnum, res_doa);
    end
    repeat (20) tick();
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd2 || cap_n != cap_base + 2) begin
      errors++; $display("FAIL run_drop_idle: got busy=%b cnt=%0d caps=%0d expected 0 2 %0d", busy, frame_cnt, cap_n - cap_base, 2);
    end
  endtask

  task automatic test_skip();
    int c1, c2, c3, wb_base, v_base;
    wb_base = wb_n; v_base = valid_n;
    run = 1;
    tick();
    run = 0;
    run_stage(0, 1, 1, 1, c1);
    run_stage(1, 1, 1, 1, c2);
    run_stage(2, 3, 1, 0, c3);
    repeat (25) tick();
    checks++;
    if (c1 < 0 || c2 < 0 || c3 < 0 || wb_n != wb_base || valid_n != v_base) begin
      errors++; $display("FAIL skip_no_wb: got strobes=%0d/%0d/%0d wb=%0d valid=%0d expected none", c1, c2, c3,
                         wb_n - wb_base, valid_n - v_base);
    end
    checks++;
    if (skip_cnt !== 16'd1 || frame_cnt !== 16'd2 || res_doa !== 8'hE2 || res_bnum !== 4'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL skip_state: got skip=%0d frames=%0d doa=%h bnum=%0d busy=%b expected 1 2 e2 3 0",
                         skip_cnt, frame_cnt, res_doa, res_bnum, busy);
    end
  endtask

  task automatic test_watchdog();
    int c1, f, e, n, cap_base;
    run = 1;
    tick();
    run = 0;
    run_stage(0, 2, 1, 1, c1);
    run_stage(1, 0, 0, 0, f);
    n = 0;
    while (n < 300 && err !== 1'b1) begin
      tick();
      n++;
    end
    e = cyc;
    checks++;
    if (f < 0 || e != f + 100) begin
      errors++; $display("FAIL wdg_time: got err at %0d expected %0d", e, f + 100);
    end
    checks++;
    if (err !== 1'b1 || err_stage !== 2'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL wdg_state: got err=%b stage=%0d busy=%b expected 1 1 0", err, err_stage, busy);
    end
    cap_base = cap_n;
    run = 1; single = 1;
    repeat (5) tick();
    checks++;
    if (err !== 1'b1 || cap_n != cap_base || frame_cnt !== 16'd2 || res_doa !== 8'hE2) begin
      errors++; $display("FAIL error_hold: got err=%b caps=%0d cnt=%0d doa=%h expected 1 0 2 e2", err,
                         cap_n - cap_base, frame_cnt, res_doa);
    end
    run = 0; single = 0; clr_err = 1;
    tick();
    clr_err = 0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL clr_err: got err=%b busy=%b expected 0 0", err, busy);
    end
    repeat (10) tick();
    checks++;
    if (cap_n != cap_base) begin
      errors++; $display("FAIL clr_err_no_strobe: got %0d cap strobes expected 0", cap_n - cap_base);
    end
  endtask

  task automatic test_single();
    int c, x, cap_base;
    cap_base = cap_n;
    wb_bnum = 4'd12; wb_doa = 8'h5A;
    single = 1;
    tick();
    single = 0;
    run_stage(0, 3, 1, 1, c);
    single = 1;
    run_stage(1, 3, 1, 1, x);
    single = 0;
    run_stage(2, 3, 1, 1, x);
    run_stage(3, 3, 1, 1, x);
    checks++;
    if (c < 0 || res_valid !== 1'b1 || res_bnum !== 4'd12 || res_doa !== 8'h5A) begin
      errors++; $display("FAIL single_publish: got valid=%b bnum=%0d doa=%h expected 1 12 5a", res_valid, res_bnum, res_doa);
    end
    repeat (40) tick();
    checks++;
    if (busy !== 1'b0 || cap_n != cap_base + 1 || frame_cnt !== 16'd3) begin
      errors++; $display("FAIL single_one_frame: got busy=%b caps=%0d cnt=%0d expected 0 1 3", busy,
                         cap_n - cap_base, frame_cnt);
    end
  endtask

  task automatic test_corner();
    int x, fft_base;
    logic [15:0] skip_base;
    fft_base = fft_n; skip_base = skip_cnt;
    wb_bnum = 4'd0; wb_doa = 8'hA6;
    run = 1;
    tick();
    run = 0;
    tick();
    det_done = 1; det_found = 0;
    tick();
    det_done = 0;
    tick();
    checks++;
    if (busy !== 1'b1 || fft_n != fft_base || skip_cnt !== skip_base) begin
      errors++; $display("FAIL stray_det_done: got busy=%b ffts=%0d skip=%0d expected 1 0 %0d", busy,
                         fft_n - fft_base, skip_cnt, skip_base);
    end
    cap_done = 1;
    tick();
    cap_done = 0;
    checks++;
    if (fft_start !== 1'b1) begin
      errors++; $display("FAIL cap_after_stray: got fft_start=%b expected 1", fft_start);
    end
    run_stage(1, 1, 1, 1, x);
    run_stage(2, 1, 1, 1, x);
    run_stage(3, 99, 1, 1, x);
    checks++;
    if (x < 0 || res_valid !== 1'b1 || err !== 1'b0 || res_doa !== 8'hA6) begin
      errors++; $display("FAIL done_beats_timeout: got valid=%b err=%b doa=%h expected 1 0 a6", res_valid, err, res_doa);
    end
    repeat (20) tick();
  endtask

  task automatic test_reset_mid();
    int x, w, v_base;
    wb_bnum = 4'd5; wb_doa = 8'd60;
    run = 1;
    tick();
    run = 0;
    run_stage(0, 1, 1, 1, x);
    run_stage(1, 1, 1, 1, x);
    run_stage(2, 1, 1, 1, x);
    run_stage(3, 0, 0, 0, w);
    reset = 1;
    tick();
    checks++;
    if (w < 0 || {cap_start, fft_start, det_start, wb_start, res_valid, busy, err, err_stage} !== 9'b0) begin
      errors++; $display("FAIL reset_mid_flags: got %b expected 000000000",
                         {cap_start, fft_start, det_start, wb_start, res_valid, busy, err, err_stage});
    end
    checks++;
    if ({res_bnum, res_doa, frame_cnt, skip_cnt} !== 44'h0) begin
      errors++; $display("FAIL reset_mid_data: got %h expected 0", {res_bnum, res_doa, frame_cnt, skip_cnt});
    end
    reset = 0;
    v_base = valid_n;
    wb_done = 1;
    tick();
    wb_done = 0;
    repeat (5) tick();
    checks++;
    if (valid_n != v_base || busy !== 1'b0 || res_bnum !== 4'd0 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL late_wb_done: got valids=%0d busy=%b bnum=%0d cnt=%0d expected 0 0 0 0",
                         valid_n - v_base, busy, res_bnum, frame_cnt);
    end
  endtask

  task automatic test_wrap();
    int x;
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    wb_bnum = 4'd7; wb_doa = 8'd15;
    tick();
    run = 1;
    tick();
    run = 0;
    run_stage(0, 1, 1, 1, x);
    run_stage(1, 1, 1, 1, x);
    run_stage(2, 1, 1, 1, x);
    run_stage(3, 1, 1, 1, x);
    tick(); tick();
    checks++;
    if (x < 0 || frame_cnt !== 16'd0) begin
      errors++; $display("FAIL frame_cnt_wrap: got %0d expected 0", frame_cnt);
    end
    repeat (20) tick();
    checks++;
    if (strobe_bad != 0) begin
      errors++; $display("FAIL strobe_shape: got %0d bad strobe cycles expected 0", strobe_bad);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_skip();
    test_watchdog();
    test_single();
    test_corner();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
